can_rx_fifo: RTL

Receive-side frame buffer between the CAN controller's receiver and the TinyQV/LaRVa register bus. It captures every good frame the controller reports and applies a programmable ID acceptance filter. Accepted frames go into a DEPTH-entry FIFO, so software can drain several back-to-back frames without the controller's single receive register being overwritten.

---
 rtl/can_rx_fifo_pkg.sv | 37 +++
 rtl/can_defs.vh | 30 +++
 rtl/can_frame_ram.sv | 27 ++
 rtl/can_rx_fifo.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/can_rx_fifo_pkg.sv
// Types and constants for the CAN receive FIFO.
// Register indices and STAT layout come from the shared CAN include.
// The entry struct packs ext, rtr, dlc, id and payload into 99 bits.
package can_rx_fifo_pkg;
`include "can_defs.vh"

   localparam logic [2:0] RS_HEADID = `CAN_RS_HEADID;
   localparam logic [2:0] RS_STAT   = `CAN_RS_STAT;
   localparam logic [2:0] RS_DATA0  = `CAN_RS_DATA0;
   localparam logic [2:0] RS_DATA1  = `CAN_RS_DATA1;
   localparam logic [2:0] RS_ACODE  = `CAN_RS_ACODE;
   localparam logic [2:0] RS_AMASK  = `CAN_RS_AMASK;

   localparam int STAT_IRQEN_HI = `CAN_STAT_IRQEN_HI;
   localparam int STAT_IRQEN_LO = `CAN_STAT_IRQEN_LO;
   localparam int STAT_COUNT_HI = `CAN_STAT_COUNT_HI;
   localparam int STAT_COUNT_LO = `CAN_STAT_COUNT_LO;
   localparam int STAT_OVF      = `CAN_STAT_OVF;
   localparam int STAT_FULL     = `CAN_STAT_FULL;
   localparam int STAT_EMPTY    = `CAN_STAT_EMPTY;
   localparam int STAT_DLC_HI   = `CAN_STAT_DLC_HI;
   localparam int STAT_DLC_LO   = `CAN_STAT_DLC_LO;

   localparam int STRB_POP      = `CAN_STRB_POP;
   localparam int STRB_CLR_OVF  = `CAN_STRB_CLR_OVF;
   localparam int STRB_FLUSH    = `CAN_STRB_FLUSH;

   localparam int ENTRY_W       = `CAN_ENTRY_W;

   typedef struct packed {
      logic        ext;
      logic        rtr;
      logic [3:0]  dlc;
      logic [28:0] id;
      logic [63:0] data;
   } entry_t;
endpackage

// File: rtl/can_defs.vh
// Shared CAN register map, STAT bit positions and receive-entry width.
// Used by the controller, this receive FIFO and the driver headers.
// Plain macros so the file can be pulled into any scope more than once.
`ifndef CAN_DEFS_VH
`define CAN_DEFS_VH

`define CAN_RS_HEADID    3'd0
`define CAN_RS_STAT      3'd1
`define CAN_RS_DATA0     3'd2
`define CAN_RS_DATA1     3'd3
`define CAN_RS_ACODE     3'd4
`define CAN_RS_AMASK     3'd5

`define CAN_STAT_IRQEN_HI 31
`define CAN_STAT_IRQEN_LO 30
`define CAN_STAT_COUNT_HI 19
`define CAN_STAT_COUNT_LO 16
`define CAN_STAT_OVF      10
`define CAN_STAT_FULL     9
`define CAN_STAT_EMPTY    8
`define CAN_STAT_DLC_HI   3
`define CAN_STAT_DLC_LO   0

`define CAN_STRB_POP      8
`define CAN_STRB_CLR_OVF  9
`define CAN_STRB_FLUSH    10

`define CAN_ENTRY_W       99

`endif

// File: rtl/can_frame_ram.sv
// Frame storage: DEPTH x 99-bit register array, one write and one read port.
// Latency: write lands on the clock edge, read is combinational.
// Backpressure: none; the caller only writes into free slots.
module can_frame_ram
   import can_rx_fifo_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  entry_t        wdata,
   input  logic [AW-1:0] raddr,
   output entry_t        rdata
);

   entry_t mem [DEPTH];

   // Store a frame in the addressed slot; contents are not reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/can_rx_fifo.sv
// CAN receive buffer: ID acceptance filter in front of a DEPTH-entry frame FIFO.
// Latency: a pushed frame or a pop/flush is visible on the bus one cycle later.
// Backpressure: none to the controller; accepted frames arriving when full are dropped and set ovf.
module can_rx_fifo
   import can_rx_fifo_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frm_valid,
   input  logic        frm_ext,
   input  logic        frm_rtr,
   input  logic [28:0] frm_id,
   input  logic [3:0]  frm_dlc,
   input  logic [63:0] frm_data,
   input  logic        cs,
   input  logic [2:0]  rs,
   input  logic [3:0]  bytesel,
   input  logic [31:0] d,
   output logic [31:0] q,
   output logic        irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          ovf;
   logic [1:0]    irqen;
   logic          acode_ext, amask_ext;
   logic [28:0]   acode_id, amask_id;

   logic   empty, full, accept;
   logic   stat_wr, pop_req, clr_ovf, flush_req;
   logic   do_pop, do_push, ovf_set;
   entry_t wr_entry, rd_entry, head;
   logic   unused_d;

   assign unused_d  = d[29];

   assign empty     = (count == '0);
   assign full      = (count == CW'(DEPTH));

   // Strobes share the STAT write; bytesel[1] gates them so irqen-only writes are harmless.
   assign stat_wr   = cs & (rs == RS_STAT) & bytesel[1];
   assign pop_req   = stat_wr & d[STRB_POP];
   assign clr_ovf   = stat_wr & d[STRB_CLR_OVF];
   assign flush_req = stat_wr & d[STRB_FLUSH];

   assign accept    = (((frm_id ^ acode_id) & amask_id) == '0) &&
                      (!amask_ext || (frm_ext == acode_ext));

   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign do_pop    = pop_req & ~empty;
   assign do_push   = frm_valid & accept & ~flush_req & (~full | do_pop);
   assign ovf_set   = frm_valid & accept & ~flush_req & full & ~do_pop;

   assign wr_entry  = '{ext: frm_ext, rtr: frm_rtr, dlc: frm_dlc, id: frm_id, data: frm_data};

   can_frame_ram #(.DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .we    (do_push),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_ptr),
      .rdata (rd_entry)
   );

   assign head = empty ? '0 : rd_entry;

   // Pointer and occupancy bookkeeping; flush overrides any push or pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush_req) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Sticky overflow: a new overflow beats a simultaneous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        ovf <= 1'b0;
      else if (ovf_set) ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
   end

   // Software-writable interrupt enables and acceptance filter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irqen     <= '0;
         acode_ext <= 1'b0;
         acode_id  <= '0;
         amask_ext <= 1'b0;
         amask_id  <= '0;
      end else if (cs) begin
         if (rs == RS_STAT && bytesel[3]) irqen <= d[31:30];
         if (rs == RS_ACODE && bytesel == 4'hF) begin
            acode_ext <= d[31];
            acode_id  <= d[28:0];
         end
         if (rs == RS_AMASK && bytesel == 4'hF) begin
            amask_ext <= d[31];
            amask_id  <= d[28:0];
         end
      end
   end

   // Combinational read mux; zero whenever the peripheral is not selected.
   always_comb begin
      q = '0;
      if (cs) begin
         case (rs)
            RS_HEADID: q = {head.ext, head.rtr, 1'b0, head.id};
            RS_STAT: begin
               q[STAT_IRQEN_HI:STAT_IRQEN_LO] = irqen;
               q[STAT_COUNT_HI:STAT_COUNT_LO] = 4'(count);
               q[STAT_OVF]                    = ovf;
               q[STAT_FULL]                   = full;
               q[STAT_EMPTY]                  = empty;
               q[STAT_DLC_HI:STAT_DLC_LO]     = head.dlc;
            end
            RS_DATA0:  q = head.data[31:0];
            RS_DATA1:  q = head.data[63:32];
            RS_ACODE:  q = {acode_ext, 2'b00, acode_id};
            RS_AMASK:  q = {amask_ext, 2'b00, amask_id};
            default:   q = '0;
         endcase
      end
   end

   assign irq = (irqen[0] & ~empty) | (irqen[1] & ovf);

endmodule
